// File: rtl/fifo_burst_reader_pkg.sv
// Shared definitions for the FIFO burst controllers: state encoding and skid buffer sizing.
package fifo_burst_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_DONE  = 3'd3,
        ST_ABORT = 3'd4
    } state_e;

    localparam int unsigned SKID_DEPTH = 2;
    localparam int unsigned OCC_WIDTH  = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry in-order skid buffer; entry 0 is always the head. Flush wins over push.
module fifo_skid_buf
    import fifo_burst_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [OCC_WIDTH-1:0]  occ_o,
    output logic [DATA_WIDTH-1:0] head_o
);

    logic [DATA_WIDTH-1:0] ent0_q, ent0_d;
    logic [DATA_WIDTH-1:0] ent1_q, ent1_d;
    logic [OCC_WIDTH-1:0]  occ_q, occ_d;
    logic [OCC_WIDTH-1:0]  base;

    // Pop shifts entry 1 forward (clearing it), then push lands in the first free slot.
    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        occ_d  = occ_q;
        base   = occ_q;
        if (flush_i) begin
            ent0_d = '0;
            ent1_d = '0;
            occ_d  = '0;
        end else begin
            if (pop_i && (occ_q != '0)) begin
                ent0_d = ent1_q;
                ent1_d = '0;
                base   = occ_q - OCC_WIDTH'(1);
            end
            occ_d = base;
            if (push_i && (base < OCC_WIDTH'(SKID_DEPTH))) begin
                if (base == '0) begin
                    ent0_d = push_data_i;
                end else begin
                    ent1_d = push_data_i;
                end
                occ_d = base + OCC_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0_q <= '0;
            ent1_q <= '0;
            occ_q  <= '0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            occ_q  <= occ_d;
        end
    end

    assign occ_o  = occ_q;
    assign head_o = ent0_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// Pops a burst of words from a registered-output FIFO and streams them out on valid/ready.
module fifo_burst_reader
    import fifo_burst_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  burst_len,
    input  logic                  abort,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted
);

    localparam int unsigned SUM_WIDTH = OCC_WIDTH + 1;

    state_e                 state_q, state_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic [LEN_WIDTH-1:0]   issued_q, issued_d;
    logic [LEN_WIDTH-1:0]   delivered_q, delivered_d;
    logic                   inflight_q;
    logic                   busy_q, done_q, aborted_q;
    logic                   pop, flush;
    logic [OCC_WIDTH-1:0]   occ, occ_nx;
    logic [SUM_WIDTH-1:0]   room;

    assign pop = m_valid && m_ready;

    // Issue and state decisions look one cycle ahead so a full-rate burst has no bubbles.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        issued_d    = issued_q;
        delivered_d = delivered_q;
        fifo_rd_en  = 1'b0;
        flush       = 1'b0;
        room        = SUM_WIDTH'(occ) + SUM_WIDTH'(inflight_q) - SUM_WIDTH'(pop);
        occ_nx      = occ + OCC_WIDTH'(inflight_q) - OCC_WIDTH'(pop);

        if ((state_q == ST_RUN) && !abort && !fifo_empty && (issued_q < len_q) &&
            (room < SUM_WIDTH'(SKID_DEPTH))) begin
            fifo_rd_en = 1'b1;
        end
        if (fifo_rd_en) issued_d = issued_q + LEN_WIDTH'(1);
        if (pop)        delivered_d = delivered_q + LEN_WIDTH'(1);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d       = burst_len;
                    issued_d    = '0;
                    delivered_d = '0;
                    state_d     = (burst_len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (issued_d == len_q) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!inflight_q && (occ_nx == '0) && (delivered_d == len_q)) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_ABORT: begin
                flush = 1'b1;
                if (!inflight_q) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides any completion decided above.
        if (abort && (state_q inside {ST_RUN, ST_DRAIN, ST_DONE})) begin
            state_d = ST_ABORT;
            flush   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            issued_q    <= '0;
            delivered_q <= '0;
            inflight_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            issued_q    <= issued_d;
            delivered_q <= delivered_d;
            inflight_q  <= fifo_rd_en;
            busy_q      <= (state_d != ST_IDLE);
            done_q      <= (state_d == ST_DONE);
            aborted_q   <= (state_d == ST_ABORT) && !fifo_rd_en;
        end
    end

    fifo_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush),
        .push_i      (inflight_q),
        .push_data_i (fifo_data),
        .pop_i       (pop),
        .occ_o       (occ),
        .head_o      (m_data)
    );

    assign m_valid = (occ != '0);
    assign busy    = busy_q;
    assign done    = done_q;
    assign aborted = aborted_q;

endmodule
